// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } pipe_state_e;

    localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/stall_flush_ctrl_sat_counter.sv
// Saturating up-counter: counts qualifying cycles and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    // counter register, held once it reaches all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {W{1'b0}};
        end else if (inc && (q != ALL_ONES)) begin
            q <= q + ONE;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/stall_flush_ctrl.sv
// Pipeline sequencer: turns load-use, branch and memory-wait requests into
// per-stage write enables, IF/ID flush and ID/EX bubble, with event counters.
module stall_flush_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] freeze_cycles
);

    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
    localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1) ? 1'b1 : 1'b0;

    pipe_state_e state_r;
    pipe_state_e state_s;
    pipe_state_e ret_state_r;
    pipe_state_e ret_state_s;
    pipe_state_e eval_state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic        freeze_inc_s;

    // FSM, return-state and stall countdown registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            ret_state_r <= RUN;
            cnt_r       <= 4'd0;
        end else begin
            state_r     <= state_s;
            ret_state_r <= ret_state_s;
            cnt_r       <= cnt_s;
        end
    end

    // next-state and output decode; a released freeze behaves as its saved state
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        state_s      = state_r;
        ret_state_s  = ret_state_r;
        cnt_s        = cnt_r;
        eval_state_s = (state_r == FREEZE) ? ret_state_r : state_r;

        if (rst) begin
            state_s     = RUN;
            ret_state_s = RUN;
            cnt_s       = 4'd0;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            state_s     = FREEZE;
            ret_state_s = eval_state_s;
        end else begin
            case (eval_state_s)
                LU_STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_s       = cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_s = RUN;
                    end else begin
                        state_s = LU_STALL;
                    end
                end
                RUN: begin
                    // a taken branch squashes the consumer, so stall_req is moot
                    if (branch_taken) begin
                        ifid_flush = 1'b1;
                        state_s    = RUN;
                    end else if (stall_req) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (MULTI_STALL) begin
                            state_s = LU_STALL;
                            cnt_s   = STALL_RELOAD;
                        end else begin
                            state_s = RUN;
                        end
                    end else begin
                        state_s = RUN;
                    end
                end
                default: begin
                    state_s = RUN;
                end
            endcase
        end
    end

    assign freeze_inc_s = mem_busy & ~rst;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (idex_bubble),
        .q   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ifid_flush),
        .q   (flush_count)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk (clk),
        .rst (rst),
        .inc (freeze_inc_s),
        .q   (freeze_cycles)
    );

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Scoreboard bench: two sequencer instances (k=3/32-bit and k=1/4-bit counters)
// driven identically and checked against a pending-bubble reference model.
module tb_stall_flush_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall_req = 1'b0;
    logic branch_taken = 1'b0;
    logic mem_busy = 1'b0;

    logic pw_a, iw_a, fl_a, xw_a, bb_a, mw_a;
    logic pw_b, iw_b, fl_b, xw_b, bb_b, mw_b;
    logic [31:0] st_a, fc_a, fz_a;
    logic [3:0]  st_b, fc_b, fz_b;

    always #5 clk = ~clk;

    stall_flush_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_write(pw_a), .ifid_write(iw_a), .ifid_flush(fl_a),
        .idex_write(xw_a), .idex_bubble(bb_a), .exmem_write(mw_a),
        .stall_cycles(st_a), .flush_count(fc_a), .freeze_cycles(fz_a)
    );

    stall_flush_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_write(pw_b), .ifid_write(iw_b), .ifid_flush(fl_b),
        .idex_write(xw_b), .idex_bubble(bb_b), .exmem_write(mw_b),
        .stall_cycles(st_b), .flush_count(fc_b), .freeze_cycles(fz_b)
    );

    // ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}
    typedef struct {
        logic [5:0] ctl;
        longint     st;
        longint     fl;
        longint     fz;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int     n_cmp = 0;
    int     n_err = 0;
    int     pend [2] = '{0, 0};
    int     kk   [2] = '{3, 1};
    longint mx   [2] = '{64'd4294967295, 64'd15};
    longint c_st [2] = '{64'd0, 64'd0};
    longint c_fl [2] = '{64'd0, 64'd0};
    longint c_fz [2] = '{64'd0, 64'd0};

    // Reference: mem_busy freezes everything, otherwise owed bubbles are paid
    // first, then a taken branch flushes, then a load-use request starts k bubbles.
    task automatic model_step(input int d, input bit r, input bit sr, input bit bt,
                              input bit mb, output exp_t e);
        bit pw = 1'b1, iw = 1'b1, fl = 1'b0, xw = 1'b1, bb = 1'b0, mw = 1'b1;
        e.st = c_st[d];
        e.fl = c_fl[d];
        e.fz = c_fz[d];
        if (r) begin
            pend[d] = 0;
            c_st[d] = 0;
            c_fl[d] = 0;
            c_fz[d] = 0;
        end else begin
            if (mb) begin
                pw = 1'b0; iw = 1'b0; xw = 1'b0; mw = 1'b0;
                if (c_fz[d] < mx[d]) c_fz[d] = c_fz[d] + 1;
            end else if (pend[d] > 0) begin
                pw = 1'b0; iw = 1'b0; bb = 1'b1;
                pend[d] = pend[d] - 1;
            end else if (bt) begin
                fl = 1'b1;
            end else if (sr) begin
                pw = 1'b0; iw = 1'b0; bb = 1'b1;
                pend[d] = kk[d] - 1;
            end
            if (bb && c_st[d] < mx[d]) c_st[d] = c_st[d] + 1;
            if (fl && c_fl[d] < mx[d]) c_fl[d] = c_fl[d] + 1;
        end
        e.ctl = {pw, iw, fl, xw, bb, mw};
    endtask

    task automatic drive(input bit r, input bit sr, input bit bt, input bit mb);
        exp_t ea, eb;
        @(posedge clk);
        #1;
        rst = r; stall_req = sr; branch_taken = bt; mem_busy = mb;
        model_step(0, r, sr, bt, mb, ea);
        model_step(1, r, sr, bt, mb, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic cmp(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // monitor: pops one expectation per instance whenever one is outstanding
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                cmp("a_ctl", {58'd0, pw_a, iw_a, fl_a, xw_a, bb_a, mw_a}, e.ctl);
                cmp("a_stall_cycles", st_a, e.st);
                cmp("a_flush_count", fc_a, e.fl);
                cmp("a_freeze_cycles", fz_a, e.fz);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                cmp("b_ctl", {58'd0, pw_b, iw_b, fl_b, xw_b, bb_b, mw_b}, e.ctl);
                cmp("b_stall_cycles", st_b, e.st);
                cmp("b_flush_count", fc_b, e.fl);
                cmp("b_freeze_cycles", fz_b, e.fz);
            end
        end
    end

    initial begin
        int guard;
        // reset then idle
        repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
        // single load-use pulse
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
        // load-use pulse, freeze during the second bubble cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
        // branch and load-use together: flush only
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        // branch under freeze, then released branch flushes
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        // branch arriving during owed bubbles is ignored
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0);
        // persistent load-use: 4-bit counter saturates at 15
        repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b0);
        // reset mid-stall, then mid-freeze
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit r, sr, bt, mb;
            r  = ($urandom_range(0, 79) == 0);
            sr = ($urandom_range(0, 3) == 0);
            bt = ($urandom_range(0, 4) == 0);
            mb = ($urandom_range(0, 5) == 0);
            drive(r, sr, bt, mb);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && guard < 8) begin
            @(posedge clk);
            guard++;
        end
        if (q_a.size() > 0 || q_b.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stall_flush_ctrl.md
# stall_flush_ctrl

Pipeline sequencer that consumes hazard and control-flow requests in the 5-stage MIPS pipeline and turns them into per-stage write enables, flush and bubble controls. It sits between the load-use hazard detector, the ID-stage branch/jump resolver and the data-memory wait line on one side, and the PC, IF/ID, ID/EX and EX/MEM pipeline registers on the other. It adds multi-cycle load stalls, memory-wait freezes with resume, and saturating performance counters.

## Interface
- LOAD_STALL_CYCLES, 1: bubble cycles inserted per load-use request; legal range 1..15.
- CNT_W, 32: width of each performance counter.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall_req  in  1  load-use hazard request from the detector, active-high.
- branch_taken  in  1  branch or jump resolved taken in ID this cycle.
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  load NOP into IF/ID at the next edge.
- idex_write  out  1  ID/EX register enable.
- idex_bubble  out  1  zero ID/EX control fields at the next edge.
- exmem_write  out  1  EX/MEM and MEM/WB register enable.
- stall_cycles  out  CNT_W  cycles with idex_bubble=1.
- flush_count  out  CNT_W  number of cycles with ifid_flush=1.
- freeze_cycles  out  CNT_W  cycles with mem_busy honoured.

## Operation
- States: RUN, LU_STALL, FREEZE. Registers: state, ret_state (RUN/LU_STALL), cnt[3:0], three counters.
- Outputs are combinational from state plus current inputs. Defaults: all *_write=1, ifid_flush=0, idex_bubble=0.
- Priority per cycle: mem_busy > active load stall > branch_taken > stall_req.
- Freeze (mem_busy=1 in any state): pc_write=ifid_write=idex_write=exmem_write=0, flush=bubble=0. Next state FREEZE, ret_state=current non-FREEZE state. cnt holds.
- FREEZE with mem_busy=0: the cycle is evaluated as if in ret_state, and the next state derives from that evaluation.
- RUN, stall_req=1, no branch: pc_write=0, ifid_write=0, idex_bubble=1. If LOAD_STALL_CYCLES>1, go to LU_STALL with cnt=LOAD_STALL_CYCLES-1. Otherwise stay in RUN.
- LU_STALL: same stall outputs regardless of stall_req/branch_taken. cnt decrements each cycle; when cnt==1, next state is RUN.
- RUN, branch_taken=1: ifid_flush=1, pc_write=1. stall_req is ignored that cycle because the flushed instruction is the consumer.
- branch_taken is ignored whenever stall outputs or freeze are active. The ID instruction is re-evaluated once released.
- Counters increment on their qualifying cycle, saturate at all-ones, and never wrap.
- rst=1: state=RUN, ret_state=RUN, cnt=0, counters=0. Outputs take default values while rst is high.

## Timing
- Zero-latency response: every request affects outputs in the same cycle. Registered state affects only following cycles.
- A load-use request at cycle N with LOAD_STALL_CYCLES=k gives bubbles at N..N+k-1. Stall outputs can reassert at N+k if stall_req persists.
- Freeze mid-stall: bubble count is preserved. The total number of bubble cycles is still k, plus the frozen cycles inserted.
- mem_busy and branch_taken in the same cycle: freeze only, no flush, flush_count unchanged.
- rst asserted mid-stall or mid-freeze returns to RUN at the next edge. Counters clear.
- stall_req and branch_taken in the same cycle in RUN: flush only.

## Structure
- Package pipe_ctrl_pkg holds the state enum (RUN, LU_STALL, FREEZE) and the CNT_W default constant.
- Sub-module sat_counter #(W) has inputs clk, rst and inc, and output q. It is saturating and is instantiated three times.
- The top level contains the FSM, cnt and the output decode.

## Test plan
- Reset, then idle for 5 cycles: all *_write=1, flush=bubble=0, counters=0.
- k=1, stall_req pulse at cycle 3: only cycle 3 has pc_write=0 and idex_bubble=1. stall_cycles=1.
- k=3, stall_req pulse, mem_busy high during the 2nd stall cycle for 4 cycles: 4 frozen cycles, then 2 more bubble cycles. stall_cycles=3, freeze_cycles=4.
- branch_taken and stall_req together in RUN: ifid_flush=1, pc_write=1, idex_bubble=0. flush_count=1.
- mem_busy and branch_taken together: all writes 0, ifid_flush=0. On the next cycle with mem_busy=0 and branch_taken=1, the flush occurs.
- CNT_W=4, 20 bubble cycles: stall_cycles sticks at 15. rst mid-stall clears to RUN and zeroes counters.
